// File: rtl/ip_framer.sv
// Transmit-side IPv4 framer.
// Prepends a 20-byte IPv4 header (no options) to a 32-bit payload stream.
// Header fields are latched from sideband presented with the first payload
// beat; the header checksum is computed in a dedicated cycle before the
// header is emitted. Payload beats then pass straight through.
module ip_framer #(
    parameter logic [7:0] TTL = 8'd64,
    parameter logic       DF  = 1'b1
) (
    input  logic        clk,
    input  logic        sreset,
    output logic        axis_i_tready,
    input  logic        axis_i_tvalid,
    input  logic        axis_i_tlast,
    input  logic [31:0] axis_i_tdata,
    input  logic [3:0]  axis_i_tkeep,
    input  logic [15:0] axis_i_length,
    input  logic [7:0]  axis_i_protocol,
    input  logic [31:0] axis_i_src_ip,
    input  logic [31:0] axis_i_dst_ip,
    input  logic        axis_o_tready,
    output logic        axis_o_tvalid,
    output logic        axis_o_tlast,
    output logic [31:0] axis_o_tdata,
    output logic [3:0]  axis_o_tkeep
);

    localparam int unsigned AXIS_BYTES = 4;
    localparam int unsigned DATA_W     = AXIS_BYTES * 8;
    localparam int unsigned HALF_W     = 16;
    localparam int unsigned SUM_W      = 20;
    localparam int unsigned IDX_W      = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CSUM = 2'd1;
    localparam logic [1:0] ST_HDR  = 2'd2;
    localparam logic [1:0] ST_PAY  = 2'd3;

    localparam logic [HALF_W-1:0] HDR_BYTES     = 16'd20;
    localparam logic [7:0]        VER_IHL       = 8'h45;
    localparam logic [7:0]        TOS           = 8'h00;
    localparam logic [7:0]        FLAGS_BYTE    = {1'b0, DF, 6'h00};
    localparam logic [IDX_W-1:0]  LAST_HDR_WORD = 3'd4;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [IDX_W-1:0]  hdr_idx;
    logic [IDX_W-1:0]  hdr_idx_nxt;
    logic [HALF_W-1:0] ident;
    logic [HALF_W-1:0] tot_len;
    logic [HALF_W-1:0] csum;
    logic [7:0]        protocol;
    logic [31:0]       src_ip;
    logic [31:0]       dst_ip;
    logic [SUM_W-1:0]  csum_sum;
    logic [HALF_W:0]   csum_fold1;
    logic [HALF_W-1:0] csum_fold2;
    logic [DATA_W-1:0] hdr_word;
    logic              pay_done;

    // Last payload beat accepted: packet complete
    assign pay_done = (state == ST_PAY) && axis_i_tvalid && axis_o_tready && axis_i_tlast;

    // Ones-complement sum of the header halfwords with the checksum field zero
    always_comb begin
        csum_sum = SUM_W'({VER_IHL, TOS})
                 + SUM_W'(tot_len)
                 + SUM_W'(ident)
                 + SUM_W'({FLAGS_BYTE, 8'h00})
                 + SUM_W'({TTL, protocol})
                 + SUM_W'(src_ip[31:16])
                 + SUM_W'(src_ip[15:0])
                 + SUM_W'(dst_ip[31:16])
                 + SUM_W'(dst_ip[15:0]);
        csum_fold1 = (HALF_W+1)'(csum_sum[15:0]) + (HALF_W+1)'(csum_sum[19:16]);
        csum_fold2 = csum_fold1[15:0] + HALF_W'(csum_fold1[16]);
    end

    // Header word select; byte 0 of each wire word lands in bits [7:0]
    always_comb begin
        hdr_word = '0;
        case (hdr_idx)
            3'd0: hdr_word = {tot_len[7:0], tot_len[15:8], TOS, VER_IHL};
            3'd1: hdr_word = {8'h00, FLAGS_BYTE, ident[7:0], ident[15:8]};
            3'd2: hdr_word = {csum[7:0], csum[15:8], protocol, TTL};
            3'd3: hdr_word = {src_ip[7:0], src_ip[15:8], src_ip[23:16], src_ip[31:24]};
            3'd4: hdr_word = {dst_ip[7:0], dst_ip[15:8], dst_ip[23:16], dst_ip[31:24]};
            default: hdr_word = '0;
        endcase
    end

    // Next-state and header word index
    always_comb begin
        state_nxt   = state;
        hdr_idx_nxt = hdr_idx;
        case (state)
            ST_IDLE: begin
                if (axis_i_tvalid) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                state_nxt   = ST_HDR;
                hdr_idx_nxt = '0;
            end
            ST_HDR: begin
                if (axis_o_tready) begin
                    if (hdr_idx == LAST_HDR_WORD) begin
                        state_nxt = ST_PAY;
                    end else begin
                        hdr_idx_nxt = hdr_idx + IDX_W'(1);
                    end
                end
            end
            ST_PAY: begin
                if (pay_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stream outputs: header from registers, payload passed through
    always_comb begin
        axis_i_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        axis_o_tlast  = 1'b0;
        axis_o_tdata  = '0;
        axis_o_tkeep  = '0;
        case (state)
            ST_HDR: begin
                axis_o_tvalid = 1'b1;
                axis_o_tkeep  = 4'hF;
                axis_o_tdata  = hdr_word;
            end
            ST_PAY: begin
                axis_i_tready = axis_o_tready;
                axis_o_tvalid = axis_i_tvalid;
                axis_o_tlast  = axis_i_tlast;
                axis_o_tdata  = axis_i_tdata;
                axis_o_tkeep  = axis_i_tkeep;
            end
            default: ;
        endcase
    end

    // Control state and identification counter
    always_ff @(posedge clk) begin
        if (sreset) begin
            state   <= ST_IDLE;
            hdr_idx <= '0;
            ident   <= '0;
        end else begin
            state   <= state_nxt;
            hdr_idx <= hdr_idx_nxt;
            if (pay_done) begin
                ident <= ident + HALF_W'(1);
            end
        end
    end

    // Per-packet sideband capture and registered checksum
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && axis_i_tvalid) begin
            tot_len  <= axis_i_length + HDR_BYTES;
            protocol <= axis_i_protocol;
            src_ip   <= axis_i_src_ip;
            dst_ip   <= axis_i_dst_ip;
        end
        if (state == ST_CSUM) begin
            csum <= ~csum_fold2;
        end
    end

endmodule

// File: tb/tb_ip_framer.sv
// Testbench for ip_framer: directed header vectors, stalls, ident sequencing,
// mid-packet reset and randomized packets against a byte-level model.
module tb_ip_framer;

    logic        clk;
    logic        sreset;
    logic        axis_i_tready;
    logic        axis_i_tvalid;
    logic        axis_i_tlast;
    logic [31:0] axis_i_tdata;
    logic [3:0]  axis_i_tkeep;
    logic [15:0] axis_i_length;
    logic [7:0]  axis_i_protocol;
    logic [31:0] axis_i_src_ip;
    logic [31:0] axis_i_dst_ip;
    logic        axis_o_tready;
    logic        axis_o_tvalid;
    logic        axis_o_tlast;
    logic [31:0] axis_o_tdata;
    logic [3:0]  axis_o_tkeep;

    ip_framer dut (
        .clk             (clk),
        .sreset          (sreset),
        .axis_i_tready   (axis_i_tready),
        .axis_i_tvalid   (axis_i_tvalid),
        .axis_i_tlast    (axis_i_tlast),
        .axis_i_tdata    (axis_i_tdata),
        .axis_i_tkeep    (axis_i_tkeep),
        .axis_i_length   (axis_i_length),
        .axis_i_protocol (axis_i_protocol),
        .axis_i_src_ip   (axis_i_src_ip),
        .axis_i_dst_ip   (axis_i_dst_ip),
        .axis_o_tready   (axis_o_tready),
        .axis_o_tvalid   (axis_o_tvalid),
        .axis_o_tlast    (axis_o_tlast),
        .axis_o_tdata    (axis_o_tdata),
        .axis_o_tkeep    (axis_o_tkeep)
    );

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    bit          stim_ok;
    logic [15:0] model_ident;
    logic [36:0] obs_q[$];
    int          obs_cyc[$];
    logic [36:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: 0 = always, 1 = random 50%, 2 = never
    initial begin
        axis_o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: axis_o_tready = 1'b1;
                1: axis_o_tready = 1'($urandom_range(0, 1));
                default: axis_o_tready = 1'b0;
            endcase
        end
    end

    // Output monitor: records each accepted beat as {last, keep, data}
    initial forever begin
        @(negedge clk);
        if (axis_o_tvalid && axis_o_tready) begin
            obs_q.push_back({axis_o_tlast, axis_o_tkeep, axis_o_tdata});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference model: header built as a byte array, then payload packed 4 bytes/beat
    task automatic build_expected(input logic [7:0] pay[$], input logic [7:0] proto,
                                  input logic [31:0] src, input logic [31:0] dst,
                                  input logic [15:0] id);
        logic [7:0]  hb[20];
        logic [15:0] tl;
        logic [15:0] cs;
        logic [31:0] d;
        logic [3:0]  kp;
        int          s;
        int          nb;
        tl = 16'(pay.size() + 20);
        hb[0] = 8'h45; hb[1] = 8'h00; hb[2] = tl[15:8]; hb[3] = tl[7:0];
        hb[4] = id[15:8]; hb[5] = id[7:0]; hb[6] = 8'h40; hb[7] = 8'h00;
        hb[8] = 8'd64; hb[9] = proto; hb[10] = 8'h00; hb[11] = 8'h00;
        hb[12] = src[31:24]; hb[13] = src[23:16]; hb[14] = src[15:8]; hb[15] = src[7:0];
        hb[16] = dst[31:24]; hb[17] = dst[23:16]; hb[18] = dst[15:8]; hb[19] = dst[7:0];
        s = 0;
        for (int i = 0; i < 10; i++) s += int'({hb[2*i], hb[2*i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~16'(s);
        hb[10] = cs[15:8];
        hb[11] = cs[7:0];
        for (int w = 0; w < 5; w++)
            exp_q.push_back({1'b0, 4'hF, hb[4*w+3], hb[4*w+2], hb[4*w+1], hb[4*w]});
        nb = (pay.size() + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            kp = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*b + k < pay.size()) begin
                    d[8*k +: 8] = pay[4*b + k];
                    kp[k] = 1'b1;
                end
            end
            exp_q.push_back({(b == nb - 1), kp, d});
        end
    endtask

    // Upstream driver; called and returns just after a rising edge
    task automatic send_payload(input logic [7:0] pay[$], input logic [7:0] proto,
                                input logic [31:0] src, input logic [31:0] dst,
                                input bit gaps);
        int          nb;
        int          g;
        int          budget;
        logic [31:0] d;
        logic [3:0]  kp;
        nb = (pay.size() + 3) / 4;
        axis_i_length   = 16'(pay.size());
        axis_i_protocol = proto;
        axis_i_src_ip   = src;
        axis_i_dst_ip   = dst;
        for (int b = 0; b < nb; b++) begin
            if (gaps && b > 0) begin
                g = $urandom_range(0, 2);
                axis_i_tvalid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            d = '0;
            kp = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*b + k < pay.size()) begin
                    d[8*k +: 8] = pay[4*b + k];
                    kp[k] = 1'b1;
                end
            end
            axis_i_tdata  = d;
            axis_i_tkeep  = kp;
            axis_i_tlast  = (b == nb - 1);
            axis_i_tvalid = 1'b1;
            budget = 0;
            do begin @(negedge clk); budget++; end while (!axis_i_tready && budget < 2000);
            if (!axis_i_tready) begin
                stim_ok = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
    endtask

    task automatic rand_payload(input int len, output logic [7:0] pay[$]);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    task automatic wait_output();
        int budget;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
    endtask

    // One packet through the model and DUT, ident advanced on completion
    task automatic run_pkt(input int len, input logic [7:0] proto, input logic [31:0] src,
                           input logic [31:0] dst, input bit gaps);
        logic [7:0] pay[$];
        rand_payload(len, pay);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        stim_ok = 1'b1;
        build_expected(pay, proto, src, dst, model_ident);
        send_payload(pay, proto, src, dst, gaps);
        wait_output();
        model_ident = model_ident + 16'd1;
    endtask

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        sreset = 1'b1;
        @(posedge clk);
        #1;
        sreset = 1'b0;
        model_ident = 16'd0;
    endtask

    task automatic test_reset();
        sreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sreset = 1'b0;
        model_ident = 16'd0;
        @(negedge clk);
        checks++;
        if (axis_o_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", axis_o_tvalid);
        else passed++;
        checks++;
        if (axis_i_tready !== 1'b0) $display("FAIL reset_tready got %b want 0", axis_i_tready);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_known();
        logic [7:0]  pay[$];
        logic [31:0] ref_w[5];
        int          lat;
        int          d;
        int          nlast;
        ref_w = '{32'h73000045, 32'h00400000, 32'h61B81140, 32'h0100A8C0, 32'hC700A8C0};
        ready_mode = 0;
        rand_payload(95, pay);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        stim_ok = 1'b1;
        build_expected(pay, 8'h11, 32'hC0A80001, 32'hC0A800C7, model_ident);
        lat = 0;
        fork
            send_payload(pay, 8'h11, 32'hC0A80001, 32'hC0A800C7, 1'b0);
            begin
                forever begin
                    @(negedge clk);
                    if (axis_o_tvalid || lat >= 20) break;
                    lat++;
                end
            end
        join
        wait_output();
        model_ident = model_ident + 16'd1;
        checks++;
        if (lat != 2) $display("FAIL known_latency got %0d want 2", lat);
        else passed++;
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (obs_q.size() <= w || obs_q[w][31:0] !== ref_w[w])
                $display("FAIL known_hdr_word%0d got %h want %h", w,
                         (obs_q.size() > w) ? obs_q[w][31:0] : 32'hx, ref_w[w]);
            else passed++;
        end
        checks++;
        if (obs_q.size() != 29) $display("FAIL known_beats got %0d want 29", obs_q.size());
        else passed++;
        nlast = 0;
        foreach (obs_q[i]) if (obs_q[i][36]) nlast++;
        checks++;
        if (obs_q.size() != 29 || nlast != 1 || obs_q[28][36:32] !== 5'b1_0111)
            $display("FAIL known_last got nlast=%0d last_keep=%h want nlast=1 keep=7", nlast,
                     (obs_q.size() == 29) ? obs_q[28][35:32] : 4'hx);
        else passed++;
        d = first_diff();
        checks++;
        if (d != -1) $display("FAIL known_model got diff at %0d want none", d);
        else passed++;
        checks++;
        if (!stim_ok) $display("FAIL known_timeout got timeout want completion");
        else passed++;
    endtask

    task automatic test_stall();
        int d;
        ready_mode = 1;
        for (int p = 0; p < 20; p++) begin
            run_pkt($urandom_range(1, 60), 8'($urandom), $urandom, $urandom, 1'b1);
            d = first_diff();
            checks++;
            if (d != -1 || !stim_ok)
                $display("FAIL stall_pkt%0d got diff=%0d ok=%0d want diff=-1 ok=1", p, d, stim_ok);
            else passed++;
        end
        ready_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pa[$];
        logic [7:0]  pb[$];
        logic [15:0] id_a;
        logic [15:0] id_b;
        int          na;
        int          d;
        ready_mode = 0;
        do_reset();
        rand_payload(10, pa);
        rand_payload(7, pb);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        stim_ok = 1'b1;
        build_expected(pa, 8'h06, 32'h0A000001, 32'h0A000002, 16'h0000);
        build_expected(pb, 8'h01, 32'h0A000003, 32'h0A000004, 16'h0001);
        na = 5 + 3;
        send_payload(pa, 8'h06, 32'h0A000001, 32'h0A000002, 1'b0);
        send_payload(pb, 8'h01, 32'h0A000003, 32'h0A000004, 1'b0);
        wait_output();
        model_ident = 16'd2;
        d = first_diff();
        checks++;
        if (d != -1 || !stim_ok) $display("FAIL b2b_model got diff=%0d ok=%0d want -1/1", d, stim_ok);
        else passed++;
        id_a = (obs_q.size() > 1) ? {obs_q[1][7:0], obs_q[1][15:8]} : 16'hxxxx;
        id_b = (obs_q.size() > na + 1) ? {obs_q[na+1][7:0], obs_q[na+1][15:8]} : 16'hxxxx;
        checks++;
        if (id_a !== 16'h0000) $display("FAIL b2b_ident_a got %h want 0000", id_a);
        else passed++;
        checks++;
        if (id_b !== 16'h0001) $display("FAIL b2b_ident_b got %h want 0001", id_b);
        else passed++;
        checks++;
        if (obs_cyc.size() <= na || obs_cyc[na] - obs_cyc[na-1] - 1 != 2)
            $display("FAIL b2b_gap got %0d want 2",
                     (obs_cyc.size() > na) ? obs_cyc[na] - obs_cyc[na-1] - 1 : -1);
        else passed++;
    endtask

    task automatic test_ident_wrap();
        logic [15:0] id;
        int          d;
        ready_mode = 0;
        force dut.ident = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.ident;
        model_ident = 16'hFFFF;
        for (int p = 0; p < 2; p++) begin
            run_pkt($urandom_range(1, 20), 8'h11, $urandom, $urandom, 1'b0);
            id = (obs_q.size() > 1) ? {obs_q[1][7:0], obs_q[1][15:8]} : 16'hxxxx;
            checks++;
            if (id !== ((p == 0) ? 16'hFFFF : 16'h0000))
                $display("FAIL wrap_ident%0d got %h want %h", p, id, (p == 0) ? 16'hFFFF : 16'h0000);
            else passed++;
            d = first_diff();
            checks++;
            if (d != -1) $display("FAIL wrap_model%0d got diff at %0d want none", p, d);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pay[$];
        int         budget;
        int         d;
        ready_mode = 0;
        rand_payload(12, pay);
        exp_q.delete();
        obs_q.delete();
        build_expected(pay, 8'h11, 32'h01020304, 32'h05060708, model_ident);
        axis_i_length   = 16'd12;
        axis_i_protocol = 8'h11;
        axis_i_src_ip   = 32'h01020304;
        axis_i_dst_ip   = 32'h05060708;
        axis_i_tdata    = {pay[3], pay[2], pay[1], pay[0]};
        axis_i_tkeep    = 4'hF;
        axis_i_tlast    = 1'b0;
        axis_i_tvalid   = 1'b1;
        budget = 0;
        do begin @(negedge clk); budget++; end while (!axis_o_tvalid && budget < 20);
        repeat (2) @(negedge clk);
        checks++;
        if (axis_o_tvalid !== 1'b1 || axis_o_tdata !== exp_q[2][31:0])
            $display("FAIL midrst_word2 got v=%b %h want v=1 %h", axis_o_tvalid, axis_o_tdata,
                     exp_q[2][31:0]);
        else passed++;
        sreset = 1'b1;
        axis_i_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (axis_o_tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", axis_o_tvalid);
        else passed++;
        @(posedge clk);
        #1;
        sreset = 1'b0;
        model_ident = 16'd0;
        run_pkt(9, 8'h11, 32'h01020304, 32'h05060708, 1'b0);
        d = first_diff();
        checks++;
        if (d != -1 || !stim_ok) $display("FAIL midrst_next got diff=%0d ok=%0d want -1/1", d, stim_ok);
        else passed++;
    endtask

    task automatic test_random();
        int d;
        int bad;
        ready_mode = 1;
        bad = 0;
        for (int p = 0; p < 300; p++) begin
            run_pkt($urandom_range(1, 64), 8'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
            d = first_diff();
            checks++;
            if (d != -1 || !stim_ok) begin
                if (bad < 5)
                    $display("FAIL random_pkt%0d got diff=%0d ok=%0d want -1/1", p, d, stim_ok);
                bad++;
            end else passed++;
        end
        ready_mode = 0;
    endtask

    initial begin
        sreset          = 1'b1;
        axis_i_tvalid   = 1'b0;
        axis_i_tlast    = 1'b0;
        axis_i_tdata    = '0;
        axis_i_tkeep    = '0;
        axis_i_length   = '0;
        axis_i_protocol = '0;
        axis_i_src_ip   = '0;
        axis_i_dst_ip   = '0;
        model_ident     = 16'd0;
        stim_ok         = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_known();
        test_stall();
        test_back_to_back();
        test_ident_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
